// File: rtl/dcache_wb.sv
// Direct-mapped write-back data cache. One outstanding line transfer at a time:
// a dirty victim is written back first, then the missing line is refilled.
module dcache_wb #(
  parameter int unsigned WORD_SIZE  = 32,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned NUM_LINES  = 4,
  parameter int unsigned ADDR_SIZE  = 32,
  localparam int unsigned LINE_BITS = WORD_SIZE * LINE_WORDS,
  localparam int unsigned LADDR     = ADDR_SIZE - $clog2(LINE_WORDS * WORD_SIZE / 8)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_SIZE-1:0] Address,
  input  logic [WORD_SIZE-1:0] WriteDataM,
  input  logic                 ReadEnable,
  input  logic                 WriteEnable,
  input  logic                 ByteAccess,
  output logic [WORD_SIZE-1:0] Value,
  output logic                 CacheStall,
  input  logic [LINE_BITS-1:0] MemLine,
  input  logic                 MemReady,
  output logic [LINE_BITS-1:0] WriteLine,
  output logic [LADDR-1:0]     AMem,
  output logic                 MemRead,
  output logic                 MemWrite
);

  localparam int unsigned BPW = WORD_SIZE / 8;
  localparam int unsigned BO  = $clog2(BPW);
  localparam int unsigned BOW = (BO > 0) ? BO : 1;
  localparam int unsigned WO  = $clog2(LINE_WORDS);
  localparam int unsigned IX  = $clog2(NUM_LINES);
  localparam int unsigned OFF = BO + WO;
  localparam int unsigned TW  = ADDR_SIZE - OFF - IX;

  typedef enum logic [1:0] {StIdle, StWriteback, StRefill} state_t;

  state_t               r_state;
  logic [NUM_LINES-1:0] r_valid;
  logic [NUM_LINES-1:0] r_dirty;
  logic [TW-1:0]        r_tag  [NUM_LINES];
  logic [LINE_BITS-1:0] r_data [NUM_LINES];
  logic                 r_mem_read;
  logic                 r_mem_write;

  logic [BOW-1:0]       w_boff;
  logic [WO-1:0]        w_woff;
  logic [IX-1:0]        w_idx;
  logic [TW-1:0]        w_tag;
  logic                 w_hit;
  logic                 w_load;
  logic                 w_store;
  logic [LINE_BITS-1:0] w_line;
  logic [LINE_BITS-1:0] w_line_st;
  logic [WORD_SIZE-1:0] w_word;
  logic [7:0]           w_byte;

  if (BO > 0) begin : g_boff
    assign w_boff = Address[BOW-1:0];
  end else begin : g_no_boff
    assign w_boff = '0;
  end

  assign w_woff  = Address[OFF-1:BO];
  assign w_idx   = Address[OFF+IX-1:OFF];
  assign w_tag   = Address[ADDR_SIZE-1:OFF+IX];
  assign w_line  = r_data[w_idx];
  assign w_hit   = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  // A simultaneous load+store is served as a load; the store is dropped.
  assign w_load  = (r_state == StIdle) && ReadEnable && w_hit;
  assign w_store = (r_state == StIdle) && WriteEnable && !ReadEnable && w_hit;

  // Word/byte extraction for loads and lane-merged line image for stores.
  always_comb begin
    w_word    = '0;
    w_byte    = '0;
    w_line_st = w_line;
    for (int w = 0; w < LINE_WORDS; w++) begin
      if (WO'(w) == w_woff) begin
        w_word = w_line[w*WORD_SIZE +: WORD_SIZE];
        for (int b = 0; b < BPW; b++) begin
          if (BOW'(b) == w_boff) w_byte = w_line[w*WORD_SIZE + b*8 +: 8];
          if (!ByteAccess || (BOW'(b) == w_boff)) begin
            w_line_st[w*WORD_SIZE + b*8 +: 8] = WriteDataM[b*8 +: 8];
          end
        end
      end
    end
  end

  assign Value      = w_load ? (ByteAccess ? WORD_SIZE'(w_byte) : w_word) : '0;
  assign CacheStall = (r_state != StIdle) || ((ReadEnable || WriteEnable) && !w_hit);
  assign AMem       = (r_state == StWriteback) ? {r_tag[w_idx], w_idx} : {w_tag, w_idx};
  assign WriteLine  = w_line;
  assign MemRead    = r_mem_read;
  assign MemWrite   = r_mem_write;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_valid     <= '0;
      r_dirty     <= '0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if ((ReadEnable || WriteEnable) && !w_hit) begin
            if (r_valid[w_idx] && r_dirty[w_idx]) begin
              r_state     <= StWriteback;
              r_mem_write <= 1'b1;
            end else begin
              r_state    <= StRefill;
              r_mem_read <= 1'b1;
            end
          end else if (w_store) begin
            r_dirty[w_idx] <= 1'b1;
          end
        end
        StWriteback: begin
          if (MemReady) begin
            r_dirty[w_idx] <= 1'b0;
            r_state        <= StRefill;
            r_mem_write    <= 1'b0;
            r_mem_read     <= 1'b1;
          end
        end
        StRefill: begin
          if (MemReady) begin
            r_valid[w_idx] <= 1'b1;
            r_dirty[w_idx] <= 1'b0;
            r_state        <= StIdle;
            r_mem_read     <= 1'b0;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Line storage is not reset; only the valid bits gate its use.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if ((r_state == StRefill) && MemReady) begin
        r_data[w_idx] <= MemLine;
        r_tag[w_idx]  <= w_tag;
      end else if (w_store) begin
        r_data[w_idx] <= w_line_st;
      end
    end
  end

endmodule

// File: doc/dcache_wb.md
DCACHE_WB -- requirements
Module: dcache_wb

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 32, data word width in bits (multiple of 8).
REQ-002 SHALL have parameter LINE_WORDS, default 4, words per line (power of 2, >=2).
REQ-003 SHALL have parameter NUM_LINES, default 4, direct-mapped line count (power of 2, >=2).
REQ-004 SHALL have parameter ADDR_SIZE, default 32, byte-address width; LINE_BITS = WORD_SIZE*LINE_WORDS; LADDR = ADDR_SIZE - log2(LINE_WORDS*WORD_SIZE/8).
REQ-005 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-006 SHALL have port rst, input, 1, reset; one clock, synchronous and active-high.
REQ-007 SHALL have ports Address (input, ADDR_SIZE, byte address) and WriteDataM (input, WORD_SIZE, store data).
REQ-008 SHALL have ports ReadEnable, WriteEnable, ByteAccess (input, 1 each): load request, store request, byte-size access when 1.
REQ-009 SHALL have port Value, output, WORD_SIZE, load result.
REQ-010 SHALL have port CacheStall, output, 1, pipeline hold.
REQ-011 SHALL have ports MemLine (input, LINE_BITS, refill data) and MemReady (input, 1, memory completion pulse).
REQ-012 SHALL have ports WriteLine (output, LINE_BITS), AMem (output, LADDR, line address), MemRead and MemWrite (output, 1 each).

Function
REQ-013 SHALL split Address as byte offset [log2(WORD_SIZE/8)-1:0], then word offset, index, tag (MSBs); hit = Valid[index] && Tag[index]==tag.
REQ-014 SHALL keep per-line Valid, Dirty, Tag, Data; states IDLE, WRITEBACK, REFILL.
REQ-015 SHALL in IDLE on load hit drive Value combinationally in the same cycle: full word, or addressed byte zero-extended when ByteAccess=1.
REQ-016 SHALL in IDLE on store hit write word (or only addressed byte lane when ByteAccess=1) at the clock edge and set Dirty[index]; no stall.
REQ-017 SHALL on miss (load or store) with victim not (Valid&&Dirty) go IDLE->REFILL; with victim Valid&&Dirty go IDLE->WRITEBACK.
REQ-018 SHALL in WRITEBACK hold MemWrite=1, AMem={Tag[index],index}, WriteLine=Data[index]; on MemReady clear Dirty and go to REFILL.
REQ-019 SHALL in REFILL hold MemRead=1, AMem={tag,index}; on MemReady write MemLine, Tag, Valid=1, Dirty=0, return to IDLE.
REQ-020 SHALL after REFILL complete the original access as a hit in IDLE (store sets Dirty then).
REQ-021 SHALL drive CacheStall = (state!=IDLE) || ((ReadEnable||WriteEnable) && !hit), combinationally.
REQ-022 SHALL register MemRead/MemWrite; asserted from the cycle after miss detection until the cycle after MemReady; never both high.
REQ-023 SHALL ignore MemReady in IDLE; requester SHALL hold Address/data/enables stable while CacheStall=1.
REQ-024 SHALL treat ReadEnable&&WriteEnable as load only (store dropped).
REQ-025 SHALL hold Value at 0 when no load hit is in progress.

Reset
REQ-026 SHALL on rst=1 at a clock edge: state IDLE, all Valid=0, Dirty=0, MemRead=0, MemWrite=0; Data/Tag arrays not cleared.
REQ-027 SHALL with rst mid-WRITEBACK/REFILL abort the transfer, drop the pending access and discard dirty data; CacheStall=0 and Value=0 after reset unless a new request misses.

Verification
REQ-028 Cold load 0x0000_0010 after reset -> CacheStall=1, REFILL with AMem=0x0000001, MemRead=1; MemReady with MemLine word0=0xAABBCCDD -> next cycle Value=0xAABBCCDD, CacheStall=0.
REQ-029 Store 0x11223344 to 0x10 (hit) then load byte 0x12 -> Value=0x00000022, zero stall cycles.
REQ-030 Dirty line at index 1, load 0x50 (same index, new tag) -> WRITEBACK, AMem=0x0000001, WriteLine carries 0x11223344 in word0; then REFILL AMem=0x0000005.
REQ-031 rst pulsed during REFILL -> MemRead=0 next cycle, IDLE, previous hit line now misses.
REQ-032 ReadEnable=WriteEnable=1 on hit -> Value returned, line data and Dirty unchanged.
REQ-033 Parameter sweep NUM_LINES=8, LINE_WORDS=8: index/offset decode and AMem width correct for line-aligned walks across all indices.
